// File: rtl/fir4_avg_out_fifo.sv
// fir4_avg_out_fifo: rounds the 4-tap FIR sum to a W-bit average, drops the warm-up beats
// after reset and buffers results in a valid/ready FIFO with a saturating overflow count.
module fir4_avg_out_fifo #(
    parameter int W      = 16,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 5,
    parameter int OVF_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [W+1:0]             in_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     warm,
    output logic [OVF_W-1:0]         overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WARMUP + 2);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] wcnt;
    logic [W-1:0]  avg;
    logic          push, pop, full, wr_en, drop;

    always_comb begin
        avg   = W'((in_sum + (W+2)'(2)) >> 2);
        push  = in_valid & warm;
        pop   = out_valid & out_ready;
        full  = level == (AW+1)'(DEPTH);
        wr_en = push & (!full | pop);
        drop  = push & full & !pop;
    end

    // Gating the read port keeps out_data defined while storage is still uninitialised
    assign out_valid = level != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= avg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            wcnt         <= '0;
            warm         <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
            if (!warm && (WARMUP == 0 || in_valid)) begin
                wcnt <= wcnt + 1'b1;
                warm <= WARMUP == 0 || wcnt == CW'(WARMUP - 1);
            end
        end
    end
endmodule

// File: tb/tb_fir4_avg_out_fifo.sv
// tb_fir4_avg_out_fifo: randomized and directed checks of fir4_avg_out_fifo against a queue model.
module tb_fir4_avg_out_fifo;
    localparam int W = 16, DEPTH = 8, WARMUP = 5, OVF_W = 8;

    logic        clk = 1'b0, reset, in_valid, out_ready, out_valid, warm;
    logic [17:0] in_sum;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic [7:0]  overflow_cnt;

    int errors = 0, checks = 0;
    int q[$];
    int m_wc, m_ovf;
    bit m_warm;

    fir4_avg_out_fifo #(.W(W), .DEPTH(DEPTH), .WARMUP(WARMUP), .OVF_W(OVF_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .warm(warm), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int avg_of(int s);
        return ((s + 2) / 4) % 65536;
    endfunction

    task automatic check_all();
        check("out_valid", out_valid, q.size() != 0);
        check("level", level, q.size());
        check("warm", warm, m_warm);
        check("overflow_cnt", overflow_cnt, m_ovf);
        if (q.size() != 0) check("out_data", out_data, q[0]);
    endtask

    task automatic model_reset();
        q.delete();
        m_wc = 0;
        m_warm = (WARMUP == 0);
        m_ovf = 0;
    endtask

    task automatic step(input bit v, input int s, input bit r);
        bit popped, was_full;
        in_valid = v;
        in_sum = 18'(s);
        out_ready = r;
        @(posedge clk);
        popped = r && q.size() != 0;
        was_full = q.size() == DEPTH;
        if (popped) void'(q.pop_front());
        if (v && m_warm) begin
            if (!was_full || popped) q.push_back(avg_of(s));
            else if (m_ovf < 255) m_ovf++;
        end else if (v) begin
            m_wc++;
            if (m_wc == WARMUP) m_warm = 1;
        end
        #1 check_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_warm", warm, 0);
        check("rst_ovf", overflow_cnt, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int dir_sums[7] = '{0, 3, 4, 6, 7, 10, 'h3FFFC};
        int rnd_sums[5] = '{1, 2, 5, 6, 'h3FFFC};
        int rnd_exp[5]  = '{0, 1, 1, 2, 'hFFFF};
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_sum = '0;
        model_reset();
        #1;
        check("init_level", level, 0);
        check("init_valid", out_valid, 0);
        check("init_data", out_data, 0);
        check("init_warm", warm, 0);
        check("init_ovf", overflow_cnt, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            step(1, dir_sums[i], 1);
            if (i == 5) check("dir_first", out_data, 3);
            if (i == 6) check("dir_second", out_data, 'hFFFF);
        end
        step(0, 0, 1);
        check("dir_empty", out_valid, 0);

        for (int i = 0; i < 5; i++) step(1, rnd_sums[i], 0);
        for (int i = 0; i < 5; i++) begin
            check("round", out_data, rnd_exp[i]);
            step(0, 0, 1);
        end

        for (int i = 0; i < 12; i++) step(1, $urandom_range(0, 4 * 65535), 0);
        check("fill_level", level, 8);
        check("fill_ovf", overflow_cnt, 4);
        step(1, $urandom_range(0, 4 * 65535), 1);
        check("full_pp_level", level, 8);
        check("full_pp_ovf", overflow_cnt, 4);
        for (int i = 0; i < 8; i++) step(0, 0, 1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4 * 65535), $urandom_range(0, 1) == 1);

        for (int i = 0; i < 310; i++) step(1, $urandom_range(0, 4 * 65535), 0);
        check("sat_ovf", overflow_cnt, 255);
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 4 * 65535), 0);
        check("sat_hold", overflow_cnt, 255);

        for (int i = 0; i < 9; i++) step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 4 * 65535), 0);
        check("mid_level", level, 5);
        async_reset();
        for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 4 * 65535), 0);
        check("rewarm_level", level, 1);
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 4 * 65535), $urandom_range(0, 3) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
